// File: rtl/gpu_sched_pkg.sv
// Shared encodings for the warp scheduler: thread states, top FSM states and
// completion kinds, plus small helpers used by the scheduler and its interface.
package gpu_sched_pkg;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_READY  = 2'd1,
    T_WAIT   = 2'd2,
    T_HALTED = 2'd3
  } thread_state_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    DK_NEXT   = 2'd0,
    DK_BRANCH = 2'd1,
    DK_HALT   = 2'd2,
    DK_RSVD   = 2'd3
  } done_kind_e;

  // Thread-id width; a single-thread build would still need one bit.
  function automatic int tid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_live(input thread_state_e s);
    return (s == T_READY) || (s == T_WAIT);
  endfunction

endpackage

// File: rtl/warp_scheduler_if.sv
// Launch, issue-handshake, completion and status bundle of the warp scheduler.
// The scheduler uses the master view; the host/fetch side uses the slave view.
interface warp_scheduler_if #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 8
) ();
  import gpu_sched_pkg::*;

  localparam int TID_W = tid_width(NUM_THREADS);

  logic                   start;
  logic [NUM_THREADS-1:0] thread_mask;

  logic                   issue_valid;
  logic                   issue_ready;
  logic [TID_W-1:0]       issue_tid;
  logic [PC_WIDTH-1:0]    issue_pc;

  logic                   done_valid;
  logic [TID_W-1:0]       done_tid;
  logic [1:0]             done_kind;
  logic [PC_WIDTH-1:0]    done_target;

  logic [NUM_THREADS-1:0] active_mask;
  logic                   busy;
  logic                   halt;

  modport master (
    input  start, thread_mask, issue_ready,
    input  done_valid, done_tid, done_kind, done_target,
    output issue_valid, issue_tid, issue_pc,
    output active_mask, busy, halt
  );

  modport slave (
    output start, thread_mask, issue_ready,
    output done_valid, done_tid, done_kind, done_target,
    input  issue_valid, issue_tid, issue_pc,
    input  active_mask, busy, halt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = gpu_sched_pkg::tid_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               grant_valid_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_o       = idx;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-thread instruction-fetch scheduler: launches a set of threads, offers
// READY threads round-robin on a registered valid/ready port, and tracks completions.
module warp_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int                  NUM_THREADS = 4,
  parameter int                  PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0] START_PC    = '0
) (
  input logic              clk,
  input logic              reset,
  warp_scheduler_if.master sched_if
);

  localparam int TID_W = tid_width(NUM_THREADS);

  typedef logic [TID_W-1:0]    tid_t;
  typedef logic [PC_WIDTH-1:0] pc_t;

  sched_state_e  fsm_q, fsm_d;
  thread_state_e thr_q [NUM_THREADS];
  thread_state_e thr_d [NUM_THREADS];
  pc_t           pc_q  [NUM_THREADS];
  pc_t           pc_d  [NUM_THREADS];
  tid_t          rr_ptr_q, rr_ptr_d;
  logic          issue_valid_q, issue_valid_d;
  tid_t          issue_tid_q, issue_tid_d;
  pc_t           issue_pc_q, issue_pc_d;

  logic [NUM_THREADS-1:0] ready_vec;
  logic [NUM_THREADS-1:0] active_vec;
  tid_t                   grant_tid;
  logic                   grant_valid;
  tid_t                   done_tid;
  logic                   done_accept;
  logic                   offer_slot_free;
  logic                   any_live;

  assign done_tid = sched_if.done_tid;

  always_comb begin
    ready_vec  = '0;
    active_vec = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      ready_vec[i]  = (thr_q[i] == T_READY);
      active_vec[i] = is_live(thr_q[i]);
    end
  end

  // Only registered READY state feeds the arbiter, so a thread completed this
  // cycle cannot be offered until the following edge.
  rr_arbiter #(
    .NUM_REQ (NUM_THREADS),
    .IDX_W   (TID_W)
  ) u_rr_arbiter (
    .req_i         (ready_vec),
    .ptr_i         (rr_ptr_q),
    .grant_o       (grant_tid),
    .grant_valid_o (grant_valid)
  );

  // A completion for the thread still sitting in the offer register is stale.
  assign done_accept = sched_if.done_valid
                    && (thr_q[done_tid] == T_WAIT)
                    && !(issue_valid_q && (issue_tid_q == done_tid));

  assign offer_slot_free = !issue_valid_q || sched_if.issue_ready;

  always_comb begin
    fsm_d         = fsm_q;
    thr_d         = thr_q;
    pc_d          = pc_q;
    rr_ptr_d      = rr_ptr_q;
    issue_valid_d = issue_valid_q;
    issue_tid_d   = issue_tid_q;
    issue_pc_d    = issue_pc_q;
    any_live      = 1'b0;

    case (fsm_q)
      S_IDLE, S_DONE: begin
        if (sched_if.start) begin
          for (int i = 0; i < NUM_THREADS; i++) begin
            thr_d[i] = sched_if.thread_mask[i] ? T_READY : T_IDLE;
            pc_d[i]  = START_PC;
          end
          rr_ptr_d = '0;
          fsm_d    = (sched_if.thread_mask == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        if (done_accept) begin
          case (done_kind_e'(sched_if.done_kind))
            DK_BRANCH: begin
              pc_d[done_tid]  = sched_if.done_target;
              thr_d[done_tid] = T_READY;
            end
            DK_HALT: thr_d[done_tid] = T_HALTED;
            default: begin
              pc_d[done_tid]  = pc_q[done_tid] + pc_t'(1);
              thr_d[done_tid] = T_READY;
            end
          endcase
        end

        if (offer_slot_free) begin
          issue_valid_d = grant_valid;
          if (grant_valid) begin
            issue_tid_d      = grant_tid;
            issue_pc_d       = pc_q[grant_tid];
            thr_d[grant_tid] = T_WAIT;
            rr_ptr_d = (grant_tid == tid_t'(NUM_THREADS - 1)) ? '0 : grant_tid + tid_t'(1);
          end
        end

        any_live = issue_valid_d;
        for (int i = 0; i < NUM_THREADS; i++) begin
          if (is_live(thr_d[i])) any_live = 1'b1;
        end
        if (!any_live) fsm_d = S_DONE;
      end

      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q         <= S_IDLE;
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_tid_q   <= '0;
      issue_pc_q    <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        thr_q[i] <= T_IDLE;
        pc_q[i]  <= '0;
      end
    end else begin
      fsm_q         <= fsm_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_tid_q   <= issue_tid_d;
      issue_pc_q    <= issue_pc_d;
      thr_q         <= thr_d;
      pc_q          <= pc_d;
    end
  end

  assign sched_if.issue_valid = issue_valid_q;
  assign sched_if.issue_tid   = issue_tid_q;
  assign sched_if.issue_pc    = issue_pc_q;
  assign sched_if.active_mask = active_vec;
  assign sched_if.busy        = (fsm_q == S_RUN);
  assign sched_if.halt        = (fsm_q == S_DONE);

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: a vector table for the round-robin run,
// plus hand sequences for offer hold, branch/wrap, stale completions and reset.
module tb_warp_scheduler;
  import gpu_sched_pkg::*;

  localparam int NT = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  warp_scheduler_if #(.NUM_THREADS(NT), .PC_WIDTH(PW)) sif ();

  warp_scheduler #(
    .NUM_THREADS (NT),
    .PC_WIDTH    (PW),
    .START_PC    (8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sched_if (sif)
  );

  typedef struct packed {
    logic       st;
    logic [3:0] mask;
    logic       rdy;
    logic       dv;
    logic [1:0] dtid;
    logic [1:0] dk;
    logic [7:0] dt;
    logic       ev;
    logic [1:0] etid;
    logic [7:0] epc;
    logic [3:0] eact;
    logic       eb;
    logic       eh;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] mask, input logic rdy,
                               input logic dv, input logic [1:0] dtid, input logic [1:0] dk,
                               input logic [7:0] dt);
    sif.start       = st;
    sif.thread_mask = mask;
    sif.issue_ready = rdy;
    sif.done_valid  = dv;
    sif.done_tid    = dtid;
    sif.done_kind   = dk;
    sif.done_target = dt;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [1:0] etid,
                             input logic [7:0] epc, input logic [3:0] eact,
                             input logic eb, input logic eh);
    logic [16:0] act;
    logic [16:0] exp;
    act = {sif.issue_valid, sif.issue_tid, sif.issue_pc, sif.active_mask, sif.busy, sif.halt};
    exp = {ev, etid, epc, eact, eb, eh};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got v=%0b tid=%0d pc=%02h act=%04b busy=%0b halt=%0b, expected v=%0b tid=%0d pc=%02h act=%04b busy=%0b halt=%0b",
               name, sif.issue_valid, sif.issue_tid, sif.issue_pc, sif.active_mask, sif.busy,
               sif.halt, ev, etid, epc, eact, eb, eh);
    end
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //          st  mask     rdy   dv    dtid  dk    dt     | ev    etid  epc    eact     eb    eh
    vecs[0]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 4'b1011, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h00, 4'b1011, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h00, 4'b1011, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd0, 8'h00, 1'b1, 2'd3, 8'h00, 4'b1011, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd0, 8'h00, 1'b1, 2'd0, 8'h01, 4'b1011, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd3, 8'h77, 1'b1, 2'd1, 8'h01, 4'b1011, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd0, 8'h00, 1'b1, 2'd3, 8'h01, 4'b1011, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd2, 8'h00, 1'b1, 2'd0, 8'h02, 4'b1011, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd2, 8'h00, 1'b1, 2'd1, 8'h02, 4'b0011, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd2, 8'h00, 1'b0, 2'd1, 8'h02, 4'b0010, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd1, 8'h02, 4'b0000, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd1, 8'h02, 4'b0000, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd1, 8'h02, 4'b0000, 1'b0, 1'b1};

    reset = 1'b1;
    idleInputs();
    #2;
    doReset();
    checkOutput("reset_state", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0);

    // Round-robin over mask 1011 with NEXT completions, then HALT all.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].st, vecs[i].mask, vecs[i].rdy, vecs[i].dv, vecs[i].dtid,
                    vecs[i].dk, vecs[i].dt);
      checkOutput($sformatf("rr_vec[%0d]", i), vecs[i].ev, vecs[i].etid, vecs[i].epc,
                  vecs[i].eact, vecs[i].eb, vecs[i].eh);
      tick();
    end

    // Hold, stale completions, start-in-RUN, branch and PC wrap.
    doReset();
    applyStimulus(1'b1, 4'b0110, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("hold_c0", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0);
    tick(); idleInputs();
    checkOutput("hold_c1", 1'b0, 2'd0, 8'h00, 4'b0110, 1'b1, 1'b0);
    tick();
    checkOutput("hold_c2", 1'b1, 2'd1, 8'h00, 4'b0110, 1'b1, 1'b0);
    tick(); applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 8'h05);
    checkOutput("hold_c3", 1'b1, 2'd2, 8'h00, 4'b0110, 1'b1, 1'b0);
    tick(); applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd1, 8'h40);
    checkOutput("hold_c4", 1'b0, 2'd2, 8'h00, 4'b0110, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      case (k)
        1:       applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd0, 8'h00);
        2:       applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
        3:       applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'h00);
        default: applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
      endcase
      checkOutput($sformatf("held_offer[%0d]", k), 1'b1, 2'd1, 8'h05, 4'b0110, 1'b1, 1'b0);
      tick();
    end
    idleInputs();
    checkOutput("held_accept", 1'b1, 2'd1, 8'h05, 4'b0110, 1'b1, 1'b0);
    tick();
    checkOutput("branch_target", 1'b1, 2'd2, 8'h40, 4'b0110, 1'b1, 1'b0);
    tick(); applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 8'hFF);
    checkOutput("after_branch", 1'b0, 2'd2, 8'h40, 4'b0110, 1'b1, 1'b0);
    tick(); idleInputs();
    checkOutput("ff_pending", 1'b0, 2'd2, 8'h40, 4'b0110, 1'b1, 1'b0);
    tick(); applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd2, 8'h00);
    checkOutput("offer_ff", 1'b1, 2'd1, 8'hFF, 4'b0110, 1'b1, 1'b0);
    tick(); applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd0, 8'h00);
    checkOutput("tid2_halted", 1'b0, 2'd1, 8'hFF, 4'b0010, 1'b1, 1'b0);
    tick(); idleInputs();
    checkOutput("wrap_pending", 1'b0, 2'd1, 8'hFF, 4'b0010, 1'b1, 1'b0);
    tick();
    checkOutput("pc_wrap", 1'b1, 2'd1, 8'h00, 4'b0010, 1'b1, 1'b0);
    tick(); applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd2, 8'h00);
    checkOutput("last_halt", 1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, 1'b0);
    tick(); idleInputs();
    checkOutput("done_state", 1'b0, 2'd1, 8'h00, 4'b0000, 1'b0, 1'b1);

    // Reset with three threads in WAIT, stale completion, relaunch.
    doReset();
    applyStimulus(1'b1, 4'b0111, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00);
    tick(); idleInputs();
    checkOutput("rst_c1", 1'b0, 2'd0, 8'h00, 4'b0111, 1'b1, 1'b0);
    tick();
    checkOutput("rst_c2", 1'b1, 2'd0, 8'h00, 4'b0111, 1'b1, 1'b0);
    tick();
    checkOutput("rst_c3", 1'b1, 2'd1, 8'h00, 4'b0111, 1'b1, 1'b0);
    tick(); applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("rst_c4", 1'b1, 2'd2, 8'h00, 4'b0111, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0, 8'h00);
    checkOutput("in_reset", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0);
    tick(); idleInputs();
    checkOutput("stale_done", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00);
    tick(); idleInputs();
    checkOutput("relaunch_run", 1'b0, 2'd0, 8'h00, 4'b1000, 1'b1, 1'b0);
    tick();
    checkOutput("relaunch_offer", 1'b1, 2'd3, 8'h00, 4'b1000, 1'b1, 1'b0);

    // Empty launch from IDLE goes straight to DONE.
    doReset();
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00);
    tick(); idleInputs();
    checkOutput("empty_launch", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
